// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: load-use stall with configurable latency, branch flush,
// data-memory freeze, EX-stage forwarding selects and a stall performance counter.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              ex_mem_en_o,
  output logic              id_ex_bubble_o,
  output logic              if_id_flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [2:0] LAT_M1    = 3'(LOAD_LAT - 1);
  localparam logic [REG_AW-1:0] X0 = '0;

  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             uses_rs1, uses_rs2, detect, lu_stall;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  always_comb begin
    uses_rs1 = !(id_opcode_i == OP_LUI || id_opcode_i == OP_AUIPC || id_opcode_i == OP_JAL);
    uses_rs2 = (id_opcode_i == OP_R || id_opcode_i == OP_S || id_opcode_i == OP_B);
    detect   = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != X0) &&
               ((uses_rs1 && id_rs1_i == ex_rd_i) || (uses_rs2 && id_rs2_i == ex_rd_i));
    lu_stall = detect || (cnt_q != 3'd0);
  end

  // Loads in EX/MEM have no data yet, so they only forward once they reach MEM/WB.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (mem_reg_write_i && !mem_mem_read_i && mem_rd_i != X0 && mem_rd_i == ex_rs1_i)
      fwd_a_raw = 2'b10;
    else if (wb_reg_write_i && wb_rd_i != X0 && wb_rd_i == ex_rs1_i)
      fwd_a_raw = 2'b01;
    if (mem_reg_write_i && !mem_mem_read_i && mem_rd_i != X0 && mem_rd_i == ex_rs2_i)
      fwd_b_raw = 2'b10;
    else if (wb_reg_write_i && wb_rd_i != X0 && wb_rd_i == ex_rs2_i)
      fwd_b_raw = 2'b01;
  end

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    fwd_a_o        = fwd_a_raw;
    fwd_b_o        = fwd_b_raw;
    cnt_d          = cnt_q;
    stall_d        = stall_q;
    if (rst_i) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
      if_id_flush_o  = 1'b1;
      fwd_a_o        = 2'b00;
      fwd_b_o        = 2'b00;
      cnt_d          = 3'd0;
      stall_d        = '0;
    end else if (mem_busy_i) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
    end else if (branch_taken_i) begin
      // The stalled instruction is squashed, so any pending stall is dropped.
      id_ex_bubble_o = 1'b1;
      if_id_flush_o  = 1'b1;
      cnt_d          = 3'd0;
    end else if (lu_stall) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
      stall_d        = stall_q + 1'b1;
      cnt_d          = (cnt_q == 3'd0) ? LAT_M1 : cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 3'd0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises load-use detection to a configurable load latency using a stall counter. It adds opcode-aware source-register qualification, EX-stage forwarding selects, branch flush, a data-memory freeze, and a stall performance counter. It sits beside the decode stage and drives the PC, IF/ID and ID/EX control, plus the EX-stage operand muxes.

## Interface
- `REG_AW`, 5: register index width.
- `LOAD_LAT`, 1: bubble cycles per load-use hazard. Legal range is 1..7.
- `CNT_W`, 32: width of the stall performance counter.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  IF/ID holds a valid instruction.
- `id_opcode`  in  7  opcode of the instruction in ID.
- `id_rs1`, `id_rs2`  in  REG_AW each  source fields of the instruction in ID.
- `ex_valid`, `ex_mem_read`  in  1 each  ID/EX holds a valid instruction / that instruction is a load.
- `ex_rd`  in  REG_AW  destination register in EX.
- `ex_rs1`, `ex_rs2`  in  REG_AW each  source registers in EX, used for forwarding.
- `mem_reg_write`, `mem_mem_read`  in  1 each  EX/MEM instruction writes a register / is a load.
- `mem_rd`  in  REG_AW  EX/MEM destination register.
- `wb_reg_write`  in  1  MEM/WB instruction writes a register.
- `wb_rd`  in  REG_AW  MEM/WB destination register.
- `branch_taken`  in  1  EX resolved a taken branch or jump.
- `mem_busy`  in  1  data memory not ready.
- `pc_en`, `if_id_en`  out  1 each  PC / IF-ID register load enable.
- `ex_mem_en`  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- `id_ex_bubble`  out  1  inject a NOP into ID/EX.
- `if_id_flush`  out  1  clear IF/ID to a NOP.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- `stall_cycles`  out  CNT_W  count of load-use stall cycles.

## Operation
- `uses_rs1`: false for LUI (0110111), AUIPC (0010111) and JAL (1101111); true otherwise.
- `uses_rs2`: true only for R (0110011), S (0100011) and B (1100011).
- `detect` = `id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd))`.
- State is the register `cnt[2:0]`. It is 0 at reset. `lu_stall = detect | (cnt!=0)`.
- Priority, highest first:
  1. `rst`
  2. `mem_busy`
  3. `branch_taken`
  4. `lu_stall`
  5. run
- `mem_busy` (freeze): `pc_en=0`, `if_id_en=0`, `ex_mem_en=0`, `id_ex_bubble=0`, `if_id_flush=0`. `cnt` and `stall_cycles` hold.
- `branch_taken` (flush): `pc_en=1`, `if_id_en=1`, `if_id_flush=1`, `id_ex_bubble=1`, `ex_mem_en=1`. `cnt<=0`, because the stalled instruction is squashed. `stall_cycles` is not incremented.
- `lu_stall`: `pc_en=0`, `if_id_en=0`, `id_ex_bubble=1`, `ex_mem_en=1`, `if_id_flush=0`. `stall_cycles` increments by 1, wrapping modulo 2^CNT_W.
  - If `cnt==0` (first cycle): `cnt<=LOAD_LAT-1`.
  - Otherwise: `cnt<=cnt-1`.
- Run: `pc_en=1`, `if_id_en=1`, `ex_mem_en=1`, `id_ex_bubble=0`, `if_id_flush=0`.
- Forwarding (combinational, independent of the priority order above). `fwd_a` is computed as below; `fwd_b` is identical using `ex_rs2`.
  - 10 if `mem_reg_write & !mem_mem_read & mem_rd!=0 & mem_rd==ex_rs1`.
  - Else 01 if `wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1`.
  - Else 00.
  - Load data is forwarded only from MEM/WB.

## Timing
- All control outputs are combinational from the inputs and `cnt`. `cnt` and `stall_cycles` are the only registers.
- While `rst=1`:
  - Outputs: `pc_en=0`, `if_id_en=0`, `ex_mem_en=1`, `id_ex_bubble=1`, `if_id_flush=1`, `fwd_a=fwd_b=00`.
  - State: `cnt<=0`, `stall_cycles<=0`.
  - Reset mid-stall aborts the stall.
- A load-use hazard produces exactly LOAD_LAT consecutive stall cycles when there is no freeze or flush. The first stall cycle is the cycle in which `detect` is seen.
- `mem_busy` cycles during a stall extend it by the same number of cycles. The count of stall cycles is unchanged.
- While `cnt!=0`, a new `detect` does not reload `cnt`.
- `branch_taken` and `mem_busy` together: freeze wins. EX holds `branch_taken` until `mem_busy` drops.

## Test plan
- LOAD_LAT=1, EX `lw x5`, ID `add x6,x5,x1`:
  - 1 cycle with `pc_en=0`, `id_ex_bubble=1`, then run.
  - `stall_cycles` goes 0→1.
- LOAD_LAT=3, same pair:
  - 3 consecutive stall cycles, with `cnt` 2→1→0.
  - `stall_cycles`=3.
  - Fourth cycle `pc_en=1`.
- EX `lw x5`, no stall expected in either case:
  - ID `lui` with rs1 field 5.
  - ID `addi x6,x1,..` with rs2 field 5.
  - `ex_rd=0` with a matching rs field.
- `ex_rs1=3`, `mem_rd=wb_rd=3`, both writes set → `fwd_a=10`.
  - Set `mem_mem_read=1` → `fwd_a=01`.
  - Set `mem_rd=0` and `wb_rd=0` → `fwd_a=00`.
- LOAD_LAT=3, `branch_taken` on the second stall cycle:
  - `if_id_flush=1`, `id_ex_bubble=1`, `pc_en=1`.
  - Next cycle `cnt=0`, run.
- LOAD_LAT=2, `mem_busy` for 2 cycles inside a stall:
  - All enables are 0 and `cnt` holds.
  - The stall completes after 4 cycles total.
  - Asserting `rst` mid-stall returns `cnt=0` and `stall_cycles=0`.
